sha512_digest_writer: RTL and testbench

- Downstream of the sha512 core: consumes each digest/digest_valid pulse, buffers it and writes it as one 64-byte line to host memory over CCI-P channel 1.
- After the programmed number of digests are written and acknowledged, writes one completion line to the DSM base so software can poll for done.
- Removes digest writeback from the requestor; channel 1 is muxed at AFU top level.

---
 rtl/sha512_digest_writer.sv | 166 ++++++++++++++++
 tb/tb_sha512_digest_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha512_digest_writer.sv
// Buffers sha512 digests and writes each as one 64-byte line over CCI-P channel 1,
// followed by a completion line at the DSM base once every digest write is acknowledged.
module sha512_digest_writer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 42,
   parameter int unsigned MDATA_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic [ADDR_W-1:0]  cfg_out_base,
   input  logic [ADDR_W-1:0]  cfg_dsm_base,
   input  logic [31:0]        cfg_count,
   input  logic [511:0]       digest,
   input  logic               digest_valid,
   input  logic               c1_almfull,
   input  logic               c1_rsp_valid,
   output logic               c1_wr_valid,
   output logic [ADDR_W-1:0]  c1_wr_addr,
   output logic [511:0]       c1_wr_data,
   output logic [MDATA_W-1:0] c1_wr_mdata,
   output logic               busy,
   output logic               done,
   output logic               overflow
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_FLAG,
      S_WAIT_FLAG,
      S_DONE
   } state_t;

   state_t            state;
   logic [511:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  fill;
   logic [ADDR_W-1:0] out_base;
   logic [ADDR_W-1:0] dsm_base;
   logic [31:0]       count;
   logic [31:0]       issued;
   logic [31:0]       acked;
   logic [31:0]       pushed;

   logic fifo_empty;
   logic fifo_full;
   logic do_pop;
   logic want_push;
   logic push_ok;
   logic drop;

   // A full FIFO still accepts a digest when the head leaves in the same cycle.
   assign fifo_empty = (fill == '0);
   assign fifo_full  = (fill == CNT_W'(FIFO_DEPTH));
   assign do_pop     = (state == S_RUN) && !fifo_empty && !c1_almfull && (issued < count);
   assign want_push  = (state == S_RUN) && digest_valid;
   assign push_ok    = want_push && (pushed < count) && (!fifo_full || do_pop);
   assign drop       = want_push && !push_ok;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= digest;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fill        <= '0;
         out_base    <= '0;
         dsm_base    <= '0;
         count       <= '0;
         issued      <= '0;
         acked       <= '0;
         pushed      <= '0;
         c1_wr_valid <= 1'b0;
         c1_wr_addr  <= '0;
         c1_wr_data  <= '0;
         c1_wr_mdata <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         c1_wr_valid <= 1'b0;

         if (c1_rsp_valid && (state != S_IDLE) && (acked != 32'hFFFF_FFFF)) begin
            acked <= acked + 32'd1;
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            pushed <= pushed + 32'd1;
         end

         if (do_pop) begin
            rd_ptr      <= rd_ptr + PTR_W'(1);
            issued      <= issued + 32'd1;
            c1_wr_valid <= 1'b1;
            c1_wr_addr  <= out_base + ADDR_W'(issued);
            c1_wr_data  <= mem[rd_ptr];
            c1_wr_mdata <= MDATA_W'(issued);
         end

         if (push_ok && !do_pop) begin
            fill <= fill + CNT_W'(1);
         end else if (!push_ok && do_pop) begin
            fill <= fill - CNT_W'(1);
         end

         if (drop) begin
            overflow <= 1'b1;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (cfg_start) begin
                  out_base <= cfg_out_base;
                  dsm_base <= cfg_dsm_base;
                  count    <= cfg_count;
                  issued   <= '0;
                  acked    <= '0;
                  pushed   <= '0;
                  rd_ptr   <= '0;
                  wr_ptr   <= '0;
                  fill     <= '0;
                  overflow <= 1'b0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if ((issued == count) && (acked == count)) begin
                  state <= S_FLAG;
               end
            end
            S_FLAG: begin
               // Completion line: count, a valid marker and the sticky overflow flag.
               if (!c1_almfull) begin
                  c1_wr_valid <= 1'b1;
                  c1_wr_addr  <= dsm_base;
                  c1_wr_data  <= 512'({overflow, 1'b1, count});
                  c1_wr_mdata <= '1;
                  state       <= S_WAIT_FLAG;
               end
            end
            S_WAIT_FLAG: begin
               if (c1_rsp_valid) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha512_digest_writer.sv
// Directed bench for sha512_digest_writer: a job-level scoreboard predicts every line
// written on channel 1, and a simple host model returns one response per write.
module tb_sha512_digest_writer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 42;
   localparam int unsigned MW    = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           cfg_start;
   logic [AW-1:0]  cfg_out_base;
   logic [AW-1:0]  cfg_dsm_base;
   logic [31:0]    cfg_count;
   logic [511:0]   digest;
   logic           digest_valid;
   logic           c1_almfull;
   logic           c1_rsp_valid;
   logic           c1_wr_valid;
   logic [AW-1:0]  c1_wr_addr;
   logic [511:0]   c1_wr_data;
   logic [MW-1:0]  c1_wr_mdata;
   logic           busy;
   logic           done;
   logic           overflow;

   always #5 clk = ~clk;

   sha512_digest_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .MDATA_W(MW)) dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_out_base(cfg_out_base),
      .cfg_dsm_base(cfg_dsm_base), .cfg_count(cfg_count), .digest(digest),
      .digest_valid(digest_valid), .c1_almfull(c1_almfull), .c1_rsp_valid(c1_rsp_valid),
      .c1_wr_valid(c1_wr_valid), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data),
      .c1_wr_mdata(c1_wr_mdata), .busy(busy), .done(done), .overflow(overflow)
   );

   typedef struct {
      bit            is_flag;
      logic [AW-1:0] addr;
      logic [511:0]  data;
      logic [MW-1:0] mdata;
   } exp_t;

   exp_t          exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cycle = 0;
   int            start_cycle = 0;
   logic [AW-1:0] m_base, m_dsm;
   logic [31:0]   m_count, m_pushed;
   bit            m_ovf = 1'b0;
   bit            m_busy = 1'b0;
   int            job_writes = 0;
   int            writes_seen = 0;
   int            wr_cycle[$];
   logic [AW-1:0] addr_log[$];
   logic [MW-1:0] mdata_log[$];
   logic [511:0]  last_data;
   logic [AW-1:0] last_addr;
   logic          af_at_edge = 1'b0;
   int            rsp_due[$];
   int            rsp_lat = 5;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [511:0] mkd(input int i);
      logic [511:0] d;
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h9E37_79B9 * 32'(i + 1) + 32'(k);
      return d;
   endfunction

   // Job model: which digests are kept, where each lands, and when the flag line is due.
   task automatic model_start(input logic [AW-1:0] b, input logic [AW-1:0] d, input logic [31:0] c);
      exp_t e;
      if (m_busy) return;
      m_base = b; m_dsm = d; m_count = c; m_pushed = 0; m_ovf = 1'b0; m_busy = 1'b1;
      job_writes = 0;
      exp_q.delete();
      if (c == 0) begin
         e.is_flag = 1'b1; e.addr = d; e.data = '0; e.mdata = '1;
         exp_q.push_back(e);
      end
   endtask

   task automatic model_digest(input logic [511:0] dg);
      exp_t e;
      if (!m_busy) return;
      if (m_pushed >= m_count || (int'(m_pushed) - job_writes) >= int'(DEPTH)) begin
         m_ovf = 1'b1;
         return;
      end
      e.is_flag = 1'b0; e.addr = m_base + AW'(m_pushed); e.data = dg; e.mdata = MW'(m_pushed);
      exp_q.push_back(e);
      m_pushed++;
      if (m_pushed == m_count) begin
         e.is_flag = 1'b1; e.addr = m_dsm; e.data = '0; e.mdata = '1;
         exp_q.push_back(e);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_ovf = 1'b0; exp_q.delete();
   endtask

   task automatic check_outputs();
      exp_t e;
      if (c1_wr_valid !== 1'b1) return;
      check("no_issue_under_almfull", 512'(af_at_edge), 512'(0));
      wr_cycle.push_back(cycle);
      addr_log.push_back(c1_wr_addr);
      mdata_log.push_back(c1_wr_mdata);
      writes_seen++;
      last_addr = c1_wr_addr;
      last_data = c1_wr_data;
      if (exp_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected_write: got addr %0h want no write", c1_wr_addr);
      end else begin
         e = exp_q.pop_front();
         if (e.is_flag) begin
            e.data = 512'({m_ovf, 1'b1, m_count});
            m_busy = 1'b0;
         end else begin
            job_writes++;
         end
         check("wr_addr", 512'(c1_wr_addr), 512'(e.addr));
         check("wr_mdata", 512'(c1_wr_mdata), 512'(e.mdata));
         check("wr_data", c1_wr_data, e.data);
      end
   endtask

   // One cycle: check outputs mid-cycle, then act as host memory just after the edge.
   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      af_at_edge = c1_almfull;
      #1;
      cycle++;
      if (c1_wr_valid === 1'b1) rsp_due.push_back(cycle + rsp_lat);
      if (rsp_due.size() > 0 && rsp_due[0] <= cycle) begin
         c1_rsp_valid = 1'b1;
         void'(rsp_due.pop_front());
      end else begin
         c1_rsp_valid = 1'b0;
      end
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] d, input logic [31:0] c);
      cfg_out_base = b; cfg_dsm_base = d; cfg_count = c; cfg_start = 1'b1;
      model_start(b, d, c);
      tick();
      start_cycle = cycle;
      cfg_start = 1'b0;
   endtask

   task automatic send_digest(input logic [511:0] dg);
      digest = dg; digest_valid = 1'b1;
      model_digest(dg);
      tick();
      digest_valid = 1'b0;
   endtask

   task automatic wait_done(input int max, input string name);
      int n = 0;
      while (done !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: done=%b want 1 within %0d cycles", name, done, max);
      end
   endtask

   task automatic end_job_checks(input string name);
      check({name, "_busy"}, 512'(busy), 512'(0));
      check({name, "_overflow"}, 512'(overflow), 512'(m_ovf));
      check({name, "_pending"}, 512'(exp_q.size()), 512'(0));
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      tick(); tick();
      reset = 1'b0;
   endtask

   initial begin
      int hold_start, w0;
      reset = 1'b1; cfg_start = 1'b0; cfg_out_base = '0; cfg_dsm_base = '0; cfg_count = '0;
      digest = '0; digest_valid = 1'b0; c1_almfull = 1'b0; c1_rsp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_valid", 512'(c1_wr_valid), 512'(0));
      check("rst_wr_addr", 512'(c1_wr_addr), 512'(0));
      check("rst_wr_data", c1_wr_data, 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_done", 512'(done), 512'(0));
      check("rst_overflow", 512'(overflow), 512'(0));
      reset = 1'b0;
      tick();

      // Three spaced digests, then the flag line.
      w0 = writes_seen;
      do_start(42'h100, 42'h3F0, 32'd3);
      for (int i = 0; i < 3; i++) begin
         send_digest(mkd(i));
         repeat (9) tick();
      end
      wait_done(100, "t1_done");
      end_job_checks("t1");
      check("t1_third_addr", 512'(addr_log[w0 + 2]), 512'(42'h102));
      check("t1_third_mdata", 512'(mdata_log[w0 + 2]), 512'(16'd2));
      check("t1_flag_addr", 512'(last_addr), 512'(42'h3F0));
      check("t1_flag_word", 512'(last_data[33:0]), 512'(34'h1_0000_0003));

      // Almost-full held while the FIFO fills, then a burst of four.
      c1_almfull = 1'b1;
      hold_start = writes_seen;
      do_start(42'h2000, 42'h3F0, 32'd4);
      for (int i = 0; i < 4; i++) send_digest(mkd(10 + i));
      repeat (45) tick();
      check("t2_held", 512'(writes_seen - hold_start), 512'(0));
      w0 = writes_seen;
      c1_almfull = 1'b0;
      wait_done(100, "t2_done");
      end_job_checks("t2");
      if (wr_cycle.size() >= w0 + 4)
         check("t2_back_to_back", 512'(wr_cycle[w0 + 3] - wr_cycle[w0]), 512'(3));
      else
         check("t2_write_count", 512'(wr_cycle.size() - w0), 512'(4));

      // Six digests into four entries: two dropped, job stalls in RUN.
      c1_almfull = 1'b1;
      do_start(42'h3000, 42'h3F0, 32'd6);
      for (int i = 0; i < 6; i++) send_digest(mkd(20 + i));
      repeat (5) tick();
      check("t3_overflow", 512'(overflow), 512'(1));
      c1_almfull = 1'b0;
      repeat (30) tick();
      check("t3_writes", 512'(job_writes), 512'(4));
      check("t3_busy", 512'(busy), 512'(1));
      check("t3_done", 512'(done), 512'(0));
      check("t3_pending", 512'(exp_q.size()), 512'(0));
      apply_reset();

      // Zero-length job goes straight to the flag line.
      do_start(42'h6000, 42'h7000, 32'd0);
      wait_done(40, "t4_done");
      end_job_checks("t4");
      check("t4_flag_latency", 512'(wr_cycle[$] - start_cycle <= 3), 512'(1));
      check("t4_flag_addr", 512'(last_addr), 512'(42'h7000));
      check("t4_flag_word", 512'(last_data[33:0]), 512'(34'h1_0000_0000));

      // Asynchronous reset with two writes outstanding, then a clean restart.
      rsp_lat = 20;
      do_start(42'h4000, 42'h3F0, 32'd4);
      send_digest(mkd(30));
      send_digest(mkd(31));
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      check("t5_async_busy", 512'(busy), 512'(0));
      check("t5_async_addr", 512'(c1_wr_addr), 512'(0));
      check("t5_async_data", c1_wr_data, 512'(0));
      model_reset();
      tick(); tick();
      reset = 1'b0;
      repeat (25) tick();
      rsp_lat = 5;
      do_start(42'h5000, 42'h5F0, 32'd1);
      send_digest(mkd(40));
      wait_done(60, "t5_done");
      end_job_checks("t5");
      check("t5_flag_word", 512'(last_data[33:0]), 512'(34'h1_0000_0001));

      // Start pulse mid-job ignored; extra digest sets overflow; restart from DONE clears it.
      do_start(42'h8000, 42'h9000, 32'd2);
      send_digest(mkd(50));
      tick();
      do_start(42'hAAAA, 42'hBBBB, 32'd7);
      send_digest(mkd(51));
      send_digest(mkd(52));
      wait_done(80, "t6_done");
      end_job_checks("t6");
      check("t6_overflow", 512'(overflow), 512'(1));
      check("t6_flag_word", 512'(last_data[33:0]), 512'(34'h3_0000_0002));
      do_start(42'hB000, 42'h9000, 32'd1);
      check("t6_done_cleared", 512'(done), 512'(0));
      check("t6_ovf_cleared", 512'(overflow), 512'(0));
      check("t6_busy_set", 512'(busy), 512'(1));
      send_digest(mkd(60));
      wait_done(60, "t6b_done");
      end_job_checks("t6b");
      check("t6b_flag_word", 512'(last_data[33:0]), 512'(34'h1_0000_0001));

      $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
      $finish;
   end

endmodule
